accum_alu: RTL and testbench
============================

# accum_alu

Parametrised sequential accumulator ALU, the successor to the combinational 16-bit breadboard ALU. Holds a 2×WIDTH-bit accumulator and applies one of 16 operations between its low WIDTH bits and a new operand per accepted command. Multiply, divide and modulo are iterative, one bit per clock, behind a start/busy/done handshake. All other operations complete in one cycle.

## Interface
- WIDTH, 16, operand width. Accumulator and result width are 2×WIDTH. Minimum value is 4.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  command strobe; sampled only while busy=0
- op_code  in  4  operation select, sampled with start
- operand  in  WIDTH  operand B, sampled with start
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle completion pulse
- acc_out  out  2×WIDTH  accumulator contents
- err_code  out  2  [0] signed add/sub overflow; [1] divide/modulo by zero

## Operation
- A = acc[WIDTH-1:0]; B = operand, latched at acceptance.
- op_code map:
  - 0 ADD, 1 SUB
  - 2 MUL, 3 DIV, 4 MOD
  - 5 AND, 6 OR, 7 NAND, 8 NOR, 9 XOR, 10 XNOR, 11 NOT(A)
  - 12 PRESET (all ones), 13 CLEAR (zero), 14 LOAD (acc = zero-extended B), 15 NOP
- ADD/SUB:
  - A and B are two's complement.
  - acc receives the exact (WIDTH+1)-bit result, sign-extended to 2×WIDTH.
  - err_code[0]=1 when the WIDTH-bit truncated result's sign differs from the exact result's sign.
- MUL: unsigned shift-add; acc = A×B, full 2×WIDTH bits.
- DIV/MOD:
  - Unsigned restoring division; acc = zero-extended quotient or remainder.
  - If B=0: err_code[1]=1, acc unchanged, completes in one cycle with no iteration.
- Bitwise ops: WIDTH-bit result, zero-extended. err_code=00.
- FSM states:
  - IDLE: start=1 with a single-cycle op → apply, stay IDLE. start=1 with MUL or DIV/MOD (B≠0) → load counter=WIDTH, go ITER.
  - ITER: one iteration per clock. On the last iteration write acc, go IDLE.
- err_code is registered and written at every completion, including error-free ones (then 00). It holds until the next completion.
- start while busy=1 is ignored; the command is dropped, not queued.
- Reset values: acc_out=0, busy=0, done=0, err_code=00, FSM=IDLE, counter=0.
- Reset asserted mid-operation abandons the operation. No done pulse is produced for it.

## Timing
- Acceptance edge E0: clock edge with busy=0 and start=1.
- Single-cycle ops:
  - acc_out and err_code update at E0.
  - done=1 for the cycle following E0.
  - busy stays 0, so back-to-back commands are accepted every cycle.
- Iterative ops:
  - busy=1 from E0 through E(WIDTH).
  - acc_out updates at edge E(WIDTH), with busy→0 and done=1 for one cycle.
  - Latency is WIDTH cycles; acc_out holds its old value during ITER.
  - A new start is accepted at E(WIDTH+1) or later, while done is still high.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Configuration
- ACCUM_ALU_MULDIV_EN defined: MUL/DIV/MOD are built as described above.
- ACCUM_ALU_MULDIV_EN undefined:
  - Iterative datapath and ITER state are omitted.
  - op_code 2–4 complete in one cycle with acc unchanged and err_code=11 (illegal op).
  - busy is tied to 0.

## Test plan
- WIDTH=16, macro defined. rst; LOAD 11; ADD 15 → acc_out=26, err=00, done one cycle after each accept, busy never high.
- LOAD 11; SUB 15 → acc_out=0xFFFFFFFC, err=00. Then LOAD 0x7FFF; ADD 1 → acc_out=0x00008000, err=01.
- LOAD 32000; MUL 16000 → busy high 16 cycles, acc_out=512000000 at done, err=00. A start pulsed mid-MUL is ignored and acc_out is unaffected.
- LOAD 32000; DIV 0 → done next cycle, err=10, acc_out=32000. LOAD 32000; DIV 7 → 4571. LOAD 32000; MOD 7 → 3. Each of DIV 7 and MOD 7 takes 16 busy cycles.
- Start MUL; assert rst during the 5th ITER cycle → immediately acc_out=0, busy=0, done=0, err=00, and no later done. The next LOAD 5 is accepted normally.
- Macro undefined: LOAD 9; MUL 3 → done next cycle, err=11, acc_out=9, busy stays 0.

Source files
------------

// File: rtl/accum_alu.sv
// accum_alu: sequential accumulator ALU with a 2*WIDTH-bit accumulator.
//
// Each accepted command combines A = acc_out[WIDTH-1:0] with the operand B.
// MUL/DIV/MOD run one bit per clock; every other operation completes in the
// acceptance cycle.
//
// Handshake: a command (op_code, operand) is accepted on a rising clk edge
// where start=1 and busy=0. A start seen while busy=1 is dropped, not queued.
// Each completion raises done for exactly one cycle. acc_out and err_code
// change only at a completion, and they hold until the next completion.
//
// Build option ACCUM_ALU_MULDIV_EN:
//   defined   -> MUL/DIV/MOD use the iterative shift-add / restoring datapath.
//   undefined -> no iterative datapath. op_code 2..4 complete in one cycle
//                with acc unchanged and err_code=11. busy is tied low.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      command strobe, sampled only while busy=0
//   op_code    operation select (4 bits), sampled with start
//   operand    operand B (WIDTH bits), sampled with start
//   busy       iterative operation in progress
//   done       one-cycle completion pulse
//   acc_out    accumulator contents (2*WIDTH bits)
//   err_code   [0] signed add/sub overflow, [1] divide/modulo by zero
//   dbg_state  current FSM state (0 = IDLE, 1 = ITER)
module accum_alu #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         op_code,
  input  logic [WIDTH-1:0]   operand,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] acc_out,
  output logic [1:0]         err_code,
  output logic               dbg_state
);

  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB   = 4'd1,  OP_MUL   = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3,  OP_MOD   = 4'd4,  OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6,  OP_NAND  = 4'd7,  OP_NOR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9,  OP_XNOR  = 4'd10, OP_NOT   = 4'd11;
  localparam logic [3:0] OP_PRE  = 4'd12, OP_CLR   = 4'd13, OP_LOAD  = 4'd14;

  typedef enum logic {S_IDLE = 1'b0, S_ITER = 1'b1} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a;
  logic [WIDTH:0]   a_x, b_x, arith;
  logic [AW-1:0]    sc_acc;
  logic [1:0]       sc_err;
  logic             iter_op;

  assign a         = acc_out[WIDTH-1:0];
  assign a_x       = {a[WIDTH-1], a};
  assign b_x       = {operand[WIDTH-1], operand};
  assign dbg_state = state;

  // Result of a single-cycle command, applied at the acceptance edge.
  always_comb begin
    sc_acc = acc_out;
    sc_err = 2'b00;
    arith  = a_x + b_x;
    case (op_code)
      OP_ADD, OP_SUB: begin
        arith = (op_code == OP_ADD) ? (a_x + b_x) : (a_x - b_x);
        // Exact (WIDTH+1)-bit result. Overflow occurs when the WIDTH-bit
        // truncation would show a different sign.
        sc_acc    = {{(AW-WIDTH-1){arith[WIDTH]}}, arith};
        sc_err[0] = arith[WIDTH] ^ arith[WIDTH-1];
      end
      OP_MUL, OP_DIV, OP_MOD: begin
`ifdef ACCUM_ALU_MULDIV_EN
        // Only divide/modulo by zero reaches this path. MUL always iterates.
        sc_err = 2'b10;
`else
        sc_err = 2'b11;
`endif
      end
      OP_AND:  sc_acc = {{WIDTH{1'b0}}, a & operand};
      OP_OR:   sc_acc = {{WIDTH{1'b0}}, a | operand};
      OP_NAND: sc_acc = {{WIDTH{1'b0}}, ~(a & operand)};
      OP_NOR:  sc_acc = {{WIDTH{1'b0}}, ~(a | operand)};
      OP_XOR:  sc_acc = {{WIDTH{1'b0}}, a ^ operand};
      OP_XNOR: sc_acc = {{WIDTH{1'b0}}, ~(a ^ operand)};
      OP_NOT:  sc_acc = {{WIDTH{1'b0}}, ~a};
      OP_PRE:  sc_acc = '1;
      OP_CLR:  sc_acc = '0;
      OP_LOAD: sc_acc = {{WIDTH{1'b0}}, operand};
      default: ;  // NOP
    endcase
  end

`ifdef ACCUM_ALU_MULDIV_EN
  logic [CW-1:0]    cnt;
  logic             it_mul, it_mod;
  logic [AW-1:0]    mcand, prod, prod_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, rem, rem_nxt, divisor;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;

  assign iter_op = (op_code == OP_MUL) ||
                   (((op_code == OP_DIV) || (op_code == OP_MOD)) && (operand != '0));
  assign busy    = (state == S_ITER);

  // One iteration step. For MUL, shreg holds the multiplier and shifts right.
  // For DIV/MOD, shreg holds the dividend and shifts left. Quotient bits enter
  // shreg from the bottom.
  always_comb begin
    prod_nxt = shreg[0] ? (prod + mcand) : prod;
    div_sh   = {rem, shreg[WIDTH-1]};
    // The trial difference is below divisor whenever it is taken, so WIDTH
    // bits are enough to hold it.
    div_ge   = div_sh[WIDTH] || (div_sh[WIDTH-1:0] >= divisor);
    rem_nxt  = div_ge ? (div_sh[WIDTH-1:0] - divisor) : div_sh[WIDTH-1:0];
    shreg_nxt = it_mul ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], div_ge};
  end
`else
  assign iter_op = 1'b0;
  assign busy    = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && iter_op) state_nxt = S_ITER;
`ifdef ACCUM_ALU_MULDIV_EN
      S_ITER: if (cnt == CW'(1)) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_out  <= '0;
      err_code <= 2'b00;
      done     <= 1'b0;
`ifdef ACCUM_ALU_MULDIV_EN
      cnt      <= '0;
      it_mul   <= 1'b0;
      it_mod   <= 1'b0;
      mcand    <= '0;
      prod     <= '0;
      shreg    <= '0;
      rem      <= '0;
      divisor  <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (start) begin
          if (iter_op) begin
`ifdef ACCUM_ALU_MULDIV_EN
            cnt     <= CW'(WIDTH);
            it_mul  <= (op_code == OP_MUL);
            it_mod  <= (op_code == OP_MOD);
            mcand   <= {{WIDTH{1'b0}}, a};
            prod    <= '0;
            shreg   <= (op_code == OP_MUL) ? operand : a;
            rem     <= '0;
            divisor <= operand;
`endif
          end else begin
            acc_out  <= sc_acc;
            err_code <= sc_err;
            done     <= 1'b1;
          end
        end
      end
`ifdef ACCUM_ALU_MULDIV_EN
      else begin
        cnt   <= cnt - CW'(1);
        prod  <= prod_nxt;
        mcand <= mcand << 1;
        shreg <= shreg_nxt;
        rem   <= rem_nxt;
        if (cnt == CW'(1)) begin
          acc_out  <= it_mul ? prod_nxt
                             : {{WIDTH{1'b0}}, (it_mod ? rem_nxt : shreg_nxt)};
          err_code <= 2'b00;
          done     <= 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_accum_alu.sv
module tb_accum_alu;
  localparam int W = 16;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, DIV = 4'd3, MODO = 4'd4;
  localparam logic [3:0] LOAD = 4'd14;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [3:0]     op_code;
  logic [W-1:0]   operand;
  logic           busy, done;
  logic [2*W-1:0] acc_out;
  logic [1:0]     err_code;
  logic           dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  accum_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_code(op_code), .operand(operand),
    .busy(busy), .done(done), .acc_out(acc_out), .err_code(err_code),
    .dbg_state(dbg_state)
  );

  // driver: present a command for one cycle. Returns at the negedge after the
  // acceptance edge E0.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op_code = op; operand = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // driver: count negedges with busy=1 (bounded). Optionally pulse a LOAD 1
  // command at the given busy cycle, which the DUT must drop.
  task automatic wait_idle(input int inject_at, output int cyc);
    cyc = 0;
    while (busy && cyc < 64) begin
      cyc++;
      if (cyc == inject_at) begin
        start = 1'b1; op_code = LOAD; operand = 16'd1;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op_code = 4'd15; operand = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (acc_out !== 32'd0) begin n_bad++; $display("FAIL reset_acc: got %h expected %h", acc_out, 32'd0); end
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done}); end
    n_cmp++; if (err_code !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b expected 00", err_code); end
    n_cmp++; if (dbg_state !== 1'b0) begin n_bad++; $display("FAIL reset_state: got %b expected 0", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    issue(LOAD, 16'd11);
    n_cmp++; if (acc_out !== 32'd11 || done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL load11: acc %h done %b busy %b expected 0000000b 1 0", acc_out, done, busy); end
    issue(ADD, 16'd15);
    n_cmp++; if (acc_out !== 32'd26 || err_code !== 2'b00 || done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL add15: acc %h err %b done %b busy %b expected 0000001a 00 1 0", acc_out, err_code, done, busy); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_sub_overflow();
    issue(LOAD, 16'd11);
    issue(SUB, 16'd15);
    n_cmp++; if (acc_out !== 32'hFFFF_FFFC || err_code !== 2'b00) begin n_bad++; $display("FAIL sub15: acc %h err %b expected fffffffc 00", acc_out, err_code); end
    issue(LOAD, 16'h7FFF);
    issue(ADD, 16'd1);
    n_cmp++; if (acc_out !== 32'h0000_8000 || err_code !== 2'b01) begin n_bad++; $display("FAIL add_ovf: acc %h err %b expected 00008000 01", acc_out, err_code); end
    // A = 0x8000 (-32768); minus 1 is -32769, exact in 17 bits
    issue(SUB, 16'd1);
    n_cmp++; if (acc_out !== 32'hFFFF_7FFF || err_code !== 2'b01) begin n_bad++; $display("FAIL sub_ovf: acc %h err %b expected ffff7fff 01", acc_out, err_code); end
  endtask

  task automatic test_bitwise();
    logic [3:0]   ops [0:11];
    logic [W-1:0] bs  [0:11];
    logic [31:0]  exp [0:11];
    ops = '{4'd14, 4'd5, 4'd6, 4'd9, 4'd7, 4'd8, 4'd10, 4'd11, 4'd12, 4'd15, 4'd11, 4'd13};
    bs  = '{16'h1234, 16'h0FF0, 16'hF00F, 16'h00FF, 16'hFF00, 16'h1000, 16'h0F0F, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    exp = '{32'h1234, 32'h0230, 32'hF23F, 32'hF2C0, 32'h0DFF, 32'hE200, 32'h12F0, 32'hED0F,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    for (int i = 0; i < 12; i++) begin
      issue(ops[i], bs[i]);
      n_cmp++;
      if (acc_out !== exp[i] || err_code !== 2'b00 || done !== 1'b1) begin
        n_bad++;
        $display("FAIL bitwise[%0d] op %0d: acc %h err %b done %b expected %h 00 1", i, ops[i], acc_out, err_code, done, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; op_code = LOAD; operand = 16'd100;
    @(negedge clk);
    n_cmp++; if (acc_out !== 32'd100 || done !== 1'b1) begin n_bad++; $display("FAIL b2b_load: acc %h done %b expected 00000064 1", acc_out, done); end
    op_code = ADD; operand = 16'd5;
    @(negedge clk);
    n_cmp++; if (acc_out !== 32'd105 || done !== 1'b1) begin n_bad++; $display("FAIL b2b_add: acc %h done %b expected 00000069 1", acc_out, done); end
    op_code = SUB; operand = 16'd200;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (acc_out !== 32'hFFFF_FFA1 || done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_sub: acc %h done %b busy %b expected ffffffa1 1 0", acc_out, done, busy); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_end: got %b expected 0", done); end
  endtask

`ifdef ACCUM_ALU_MULDIV_EN
  task automatic test_mul();
    int cyc;
    issue(LOAD, 16'd32000);
    issue(MUL, 16'd16000);
    n_cmp++; if (busy !== 1'b1 || acc_out !== 32'd32000 || dbg_state !== 1'b1) begin n_bad++; $display("FAIL mul_start: busy %b acc %h state %b expected 1 00007d00 1", busy, acc_out, dbg_state); end
    wait_idle(3, cyc);
    n_cmp++; if (cyc !== 16) begin n_bad++; $display("FAIL mul_latency: got %0d expected 16", cyc); end
    n_cmp++; if (acc_out !== 32'd512000000 || err_code !== 2'b00 || done !== 1'b1) begin n_bad++; $display("FAIL mul_result: acc %h err %b done %b expected 1e848000 00 1", acc_out, err_code, done); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || acc_out !== 32'd512000000) begin n_bad++; $display("FAIL mul_after: done %b acc %h expected 0 1e848000", done, acc_out); end
  endtask

  task automatic test_div();
    int cyc;
    issue(LOAD, 16'd32000);
    issue(DIV, 16'd0);
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || err_code !== 2'b10 || acc_out !== 32'd32000) begin n_bad++; $display("FAIL div0: done %b busy %b err %b acc %h expected 1 0 10 00007d00", done, busy, err_code, acc_out); end
    issue(LOAD, 16'd32000);
    issue(DIV, 16'd7);
    wait_idle(0, cyc);
    n_cmp++; if (cyc !== 16 || acc_out !== 32'd4571 || err_code !== 2'b00 || done !== 1'b1) begin n_bad++; $display("FAIL div7: cycles %0d acc %h err %b done %b expected 16 000011db 00 1", cyc, acc_out, err_code, done); end
    issue(LOAD, 16'd32000);
    issue(MODO, 16'd7);
    wait_idle(0, cyc);
    n_cmp++; if (cyc !== 16 || acc_out !== 32'd3 || err_code !== 2'b00 || done !== 1'b1) begin n_bad++; $display("FAIL mod7: cycles %0d acc %h err %b done %b expected 16 00000003 00 1", cyc, acc_out, err_code, done); end
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(LOAD, 16'd32000);
    issue(DIV, 16'd0);          // leaves err_code = 10 during the MUL
    issue(MUL, 16'd16000);      // now in 1st ITER cycle
    repeat (4) @(negedge clk);  // 5th ITER cycle
    rst = 1'b1;
    #1;
    n_cmp++; if (acc_out !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || err_code !== 2'b00) begin n_bad++; $display("FAIL reset_mid: acc %h busy %b done %b err %b expected 00000000 0 0 00", acc_out, busy, done, err_code); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", seen); end
    issue(LOAD, 16'd5);
    n_cmp++; if (acc_out !== 32'd5 || done !== 1'b1) begin n_bad++; $display("FAIL reset_mid_load5: acc %h done %b expected 00000005 1", acc_out, done); end
  endtask
`else
  task automatic test_disabled();
    issue(LOAD, 16'd9);
    issue(MUL, 16'd3);
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || err_code !== 2'b11 || acc_out !== 32'd9) begin n_bad++; $display("FAIL mul_disabled: done %b busy %b err %b acc %h expected 1 0 11 00000009", done, busy, err_code, acc_out); end
    issue(DIV, 16'd3);
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || err_code !== 2'b11 || acc_out !== 32'd9) begin n_bad++; $display("FAIL div_disabled: done %b busy %b err %b acc %h expected 1 0 11 00000009", done, busy, err_code, acc_out); end
    issue(LOAD, 16'd4);
    n_cmp++; if (err_code !== 2'b00 || acc_out !== 32'd4) begin n_bad++; $display("FAIL err_cleared: err %b acc %h expected 00 00000004", err_code, acc_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub_overflow();
    test_bitwise();
    test_back_to_back();
`ifdef ACCUM_ALU_MULDIV_EN
    test_mul();
    test_div();
    test_reset_mid();
`else
    test_disabled();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
